// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and default sizes for the program-RAM arbiter.
//   state_t : arbiter sequencing states (IDLE / ACCESS / RESP)
//   owner_t : which requester owns the access in flight
//   RAM_AW / RAM_DW : default RAM address / data widths (16 x 8)
package ram_arb_pkg;

    localparam int RAM_AW = 4;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// arb_pick
// Combinational winner select between the CPU read path and the loader.
// Build option RAM_ARB_RR_EN:
//   defined   : round-robin, a tie goes to the requester not granted last
//               (i_last is the previous winner)
//   undefined : fixed priority, the loader always wins a tie (no pointer port)
// Ports:
//   i_cpu_req, i_ldr_req : raw requests
//   i_last               : previous winner (round-robin build only)
//   o_valid              : at least one request present
//   o_winner             : selected owner, meaningful only with o_valid
module arb_pick
    import ram_arb_pkg::*;
(
    input  logic   i_cpu_req,
    input  logic   i_ldr_req,
`ifdef RAM_ARB_RR_EN
    input  owner_t i_last,
`endif
    output logic   o_valid,
    output owner_t o_winner
);

    always_comb begin
        o_valid  = i_cpu_req | i_ldr_req;
        o_winner = OWN_CPU;
`ifdef RAM_ARB_RR_EN
        if (i_cpu_req && i_ldr_req) begin
            o_winner = (i_last == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (i_ldr_req) begin
            o_winner = OWN_LDR;
        end
`else
        if (i_ldr_req) begin
            o_winner = OWN_LDR;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the 16x8 program RAM between the CPU read path and the program
// loader. One access in flight: IDLE picks a winner and latches its
// address/data, ACCESS issues the RAM cycle (gnt pulse, ram_we for a loader
// write), RESP returns the synchronous read data with a one-cycle rvalid.
// Build option RAM_ARB_RR_EN selects round-robin arbitration (default: loader
// has fixed priority).
// Ports:
//   clk, clr (async, active-high)
//   cpu_req/cpu_addr -> cpu_gnt, cpu_rvalid, cpu_rdata
//   ldr_req/ldr_we/ldr_addr/ldr_wdata -> ldr_gnt, ldr_rvalid, ldr_rdata
//   ram_addr, ram_we, ram_wdata -> RAM macro; ram_rdata <- RAM macro
//   busy : state != IDLE
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    state_t        r_state;
    owner_t        r_owner;
    logic          r_is_write;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_ram_we;
    logic          r_cpu_gnt;
    logic          r_ldr_gnt;
    logic          r_cpu_rvalid;
    logic          r_ldr_rvalid;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ldr_rdata;

    logic          w_pick_valid;
    owner_t        w_pick_winner;

`ifdef RAM_ARB_RR_EN
    owner_t        r_last;
`endif

    arb_pick u_arb_pick (
        .i_cpu_req (cpu_req),
        .i_ldr_req (ldr_req),
`ifdef RAM_ARB_RR_EN
        .i_last    (r_last),
`endif
        .o_valid   (w_pick_valid),
        .o_winner  (w_pick_winner)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_is_write   <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_we     <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_ldr_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
`ifdef RAM_ARB_RR_EN
            r_last       <= OWN_CPU;
`endif
        end else begin
            // Pulses default low; each is raised for exactly one state.
            r_cpu_gnt    <= 1'b0;
            r_ldr_gnt    <= 1'b0;
            r_ram_we     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ACCESS;
                        r_owner <= w_pick_winner;
`ifdef RAM_ARB_RR_EN
                        r_last  <= w_pick_winner;
`endif
                        if (w_pick_winner == OWN_LDR) begin
                            r_ram_addr  <= ldr_addr;
                            r_ram_wdata <= ldr_wdata;
                            r_is_write  <= ldr_we;
                            r_ram_we    <= ldr_we;
                            r_ldr_gnt   <= 1'b1;
                        end else begin
                            r_ram_addr  <= cpu_addr;
                            r_is_write  <= 1'b0;
                            r_cpu_gnt   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (r_is_write) begin
                        r_state <= IDLE;
                    end else begin
                        // RAM samples ram_addr at this edge; data appears in RESP.
                        r_state <= RESP;
                        if (r_owner == OWN_LDR) begin
                            r_ldr_rvalid <= 1'b1;
                        end else begin
                            r_cpu_rvalid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_owner == OWN_LDR) begin
                        r_ldr_rdata <= ram_rdata;
                    end else begin
                        r_cpu_rdata <= ram_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // During the rvalid cycle the RAM output is forwarded directly; the
    // holding register captures it at the end of RESP and keeps it afterwards.
    assign cpu_rdata  = r_cpu_rvalid ? ram_rdata : r_cpu_rdata;
    assign ldr_rdata  = r_ldr_rvalid ? ram_rdata : r_ldr_rdata;

    assign cpu_gnt    = r_cpu_gnt;
    assign ldr_gnt    = r_ldr_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ldr_rvalid = r_ldr_rvalid;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign ram_we     = r_ram_we;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req = 1'b0;
    logic          ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          ldr_gnt, ldr_rvalid;
    logic [DW-1:0] ldr_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .clr        (clr),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    // RAM macro: synchronous read, write on ram_we.
    logic [DW-1:0] ram_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) ram_mem[i] = '0;
        forever begin
            @(posedge clk);
            ram_rdata <= ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        end
    end

    // ---------------- counters / checker ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Expectations are scheduled per cycle: cycle c is the interval after
    // rising edge number c. A grant decided at edge e shows gnt in cycle e,
    // read data in cycle e+1; the bus is free again for sampling at e+2
    // (write) or e+3 (read).
    int          cyc = 0;
    bit          e_cpu_gnt [MAXC];
    bit          e_ldr_gnt [MAXC];
    bit          e_we      [MAXC];
    bit          e_acc     [MAXC];
    bit          e_busy    [MAXC];
    bit          e_cpu_rv  [MAXC];
    bit          e_ldr_rv  [MAXC];
    logic [AW-1:0] e_addr    [MAXC];
    logic [DW-1:0] e_wdata   [MAXC];
    logic [AW-1:0] e_rv_addr [MAXC];
    logic [DW-1:0] mdl_mem [16];
    logic [DW-1:0] m_cpu_rdata = '0;
    logic [DW-1:0] m_ldr_rdata = '0;
    int          m_free = 0;
    bit          m_last_ldr = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
        for (int c = 0; c < MAXC; c++) begin
            e_cpu_gnt[c] = 0; e_ldr_gnt[c] = 0; e_we[c] = 0; e_acc[c] = 0;
            e_busy[c] = 0; e_cpu_rv[c] = 0; e_ldr_rv[c] = 0;
            e_addr[c] = '0; e_wdata[c] = '0; e_rv_addr[c] = '0;
        end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (clr) begin
                for (int c = (cyc > 0 ? cyc - 1 : 0); c < MAXC; c++) begin
                    e_cpu_gnt[c] = 0; e_ldr_gnt[c] = 0; e_we[c] = 0; e_acc[c] = 0;
                    e_busy[c] = 0; e_cpu_rv[c] = 0; e_ldr_rv[c] = 0;
                end
                m_cpu_rdata = '0;
                m_ldr_rdata = '0;
                m_free      = cyc;
                m_last_ldr  = 1'b0;
            end else begin
                // retire the previous cycle's write / read delivery
                if (e_we[cyc-1])     mdl_mem[e_addr[cyc-1]] = e_wdata[cyc-1];
                if (e_cpu_rv[cyc-1]) m_cpu_rdata = mdl_mem[e_rv_addr[cyc-1]];
                if (e_ldr_rv[cyc-1]) m_ldr_rdata = mdl_mem[e_rv_addr[cyc-1]];
                if (cyc >= m_free && cyc + 3 < MAXC && (cpu_req || ldr_req)) begin
                    bit pick_ldr;
`ifdef RAM_ARB_RR_EN
                    pick_ldr = ldr_req && (!cpu_req || !m_last_ldr);
`else
                    pick_ldr = ldr_req;
`endif
                    m_last_ldr = pick_ldr;
                    e_acc[cyc]  = 1;
                    e_busy[cyc] = 1;
                    if (pick_ldr) begin
                        e_ldr_gnt[cyc] = 1;
                        e_addr[cyc]    = ldr_addr;
                        if (ldr_we) begin
                            e_we[cyc]    = 1;
                            e_wdata[cyc] = ldr_wdata;
                            m_free       = cyc + 2;
                        end else begin
                            e_busy[cyc+1]    = 1;
                            e_ldr_rv[cyc+1]  = 1;
                            e_rv_addr[cyc+1] = ldr_addr;
                            m_free           = cyc + 3;
                        end
                    end else begin
                        e_cpu_gnt[cyc]   = 1;
                        e_addr[cyc]      = cpu_addr;
                        e_busy[cyc+1]    = 1;
                        e_cpu_rv[cyc+1]  = 1;
                        e_rv_addr[cyc+1] = cpu_addr;
                        m_free           = cyc + 3;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          n_cpu_gnt = 0, n_ldr_gnt = 0, n_rv = 0;
    logic [DW-1:0] last_cpu_rv_data = '0;

    initial begin
        forever begin
            int c;
            logic [DW-1:0] exp_crd, exp_lrd;
            @(negedge clk);
            c = cyc;
            if (clr) begin
                chk("rst_cpu_gnt", cpu_gnt, 0);
                chk("rst_ldr_gnt", ldr_gnt, 0);
                chk("rst_cpu_rvalid", cpu_rvalid, 0);
                chk("rst_ldr_rvalid", ldr_rvalid, 0);
                chk("rst_cpu_rdata", cpu_rdata, 0);
                chk("rst_ldr_rdata", ldr_rdata, 0);
                chk("rst_ram_we", ram_we, 0);
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_ram_wdata", ram_wdata, 0);
                chk("rst_busy", busy, 0);
            end else if (c < MAXC) begin
                exp_crd = e_cpu_rv[c] ? mdl_mem[e_rv_addr[c]] : m_cpu_rdata;
                exp_lrd = e_ldr_rv[c] ? mdl_mem[e_rv_addr[c]] : m_ldr_rdata;
                chk("cpu_gnt", cpu_gnt, e_cpu_gnt[c]);
                chk("ldr_gnt", ldr_gnt, e_ldr_gnt[c]);
                chk("ram_we", ram_we, e_we[c]);
                chk("cpu_rvalid", cpu_rvalid, e_cpu_rv[c]);
                chk("ldr_rvalid", ldr_rvalid, e_ldr_rv[c]);
                chk("busy", busy, e_busy[c]);
                chk("cpu_rdata", cpu_rdata, exp_crd);
                chk("ldr_rdata", ldr_rdata, exp_lrd);
                if (e_acc[c]) chk("ram_addr", ram_addr, e_addr[c]);
                if (e_we[c])  chk("ram_wdata", ram_wdata, e_wdata[c]);
            end
            n_cpu_gnt += int'(cpu_gnt);
            n_ldr_gnt += int'(ldr_gnt);
            n_rv      += int'(cpu_rvalid) + int'(ldr_rvalid);
            if (cpu_rvalid) last_cpu_rv_data = cpu_rdata;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic ldr_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        lat = 0;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = a; ldr_wdata = d;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ldr_gnt) begin lat = k; break; end
        end
        if (lat == 0) chk("ldr_write_timeout", 0, 1);
        $display("ldr write addr=%0h data=%0h gnt after %0d cycle(s) ram_we=%0b", a, d, lat, ram_we);
        ldr_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        lat = 0;
        d = '0;
        cpu_req = 1'b1; cpu_addr = a;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (cpu_gnt) begin lat = k; break; end
        end
        cpu_req = 1'b0;
        if (lat == 0) chk("cpu_read_timeout", 0, 1);
        tick();
        chk("cpu_read_rvalid", cpu_rvalid, 1);
        d = cpu_rdata;
        $display("cpu read addr=%0h data=%0h gnt after %0d cycle(s)", a, d, lat);
    endtask

    initial begin
        int lat, g_cpu, g_ldr, r0;
        logic [DW-1:0] d;
        bit ldr_first, cpu_done, ldr_done;

        // reset, idle
        repeat (3) tick();
        chk("lit_busy_in_clr", busy, 0);
        clr = 1'b0;
        repeat (2) tick();
        chk("lit_busy_idle", busy, 0);
        chk("lit_gnt_idle", cpu_gnt | ldr_gnt, 0);

        // loader write 3 <= 1E, then CPU read 3
        ldr_write(4'h3, 8'h1E, lat);
        chk("lit_ldr_lat", lat, 1);
        chk("lit_ldr_ram_we", ram_we, 1);
        chk("lit_ldr_ram_addr", ram_addr, 4'h3);
        tick();
        cpu_read(4'h3, d, lat);
        chk("lit_cpu_lat", lat, 1);
        chk("lit_cpu_rdata_1E", d, 8'h1E);
        tick();
        chk("lit_cpu_rdata_hold", cpu_rdata, 8'h1E);

        // both requests held continuously (reads)
        pulse_clr();
        g_cpu = n_cpu_gnt; g_ldr = n_ldr_gnt;
        ldr_we = 1'b0; ldr_addr = 4'h3; cpu_addr = 4'h3;
        cpu_req = 1'b1; ldr_req = 1'b1;
        repeat (12) tick();
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (3) tick();
        $display("both held: ldr grants=%0d cpu grants=%0d", n_ldr_gnt - g_ldr, n_cpu_gnt - g_cpu);
`ifdef RAM_ARB_RR_EN
        chk("lit_rr_ldr_grants", n_ldr_gnt - g_ldr, 2);
        chk("lit_rr_cpu_grants", n_cpu_gnt - g_cpu, 2);
`else
        chk("lit_fp_ldr_grants", n_ldr_gnt - g_ldr, 4);
        chk("lit_fp_cpu_grants", n_cpu_gnt - g_cpu, 0);
`endif
        chk("lit_ldr_rdata_1E", ldr_rdata, 8'h1E);

        // simultaneous: loader writes F, CPU reads F
        pulse_clr();
        g_cpu = n_cpu_gnt; g_ldr = n_ldr_gnt;
        ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'hA5; cpu_addr = 4'hF;
        ldr_req = 1'b1; cpu_req = 1'b1;
        ldr_first = 0; cpu_done = 0; ldr_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ldr_gnt) begin ldr_req = 1'b0; if (!cpu_done) ldr_first = 1; ldr_done = 1; end
            if (cpu_gnt) begin cpu_req = 1'b0; cpu_done = 1; end
        end
        $display("same-cycle F: ldr_first=%0b cpu read data=%0h", ldr_first, last_cpu_rv_data);
        chk("lit_f_ldr_first", ldr_first, 1);
        chk("lit_f_cpu_done", cpu_done & ldr_done, 1);
        chk("lit_f_rdata_A5", last_cpu_rv_data, 8'hA5);
        chk("lit_f_grants", (n_cpu_gnt - g_cpu) * 16 + (n_ldr_gnt - g_ldr), 8'h11);

        // CPU request withdrawn while loader owns the bus
        ldr_write(4'h5, 8'h5A, lat);
        cpu_req = 1'b1; cpu_addr = 4'h5;
        tick();
        cpu_req = 1'b0;
        g_cpu = n_cpu_gnt;
        repeat (4) tick();
        $display("withdrawn cpu req: cpu grants=%0d busy=%0b", n_cpu_gnt - g_cpu, busy);
        chk("lit_withdraw_no_gnt", n_cpu_gnt - g_cpu, 0);
        chk("lit_withdraw_idle", busy, 0);

        // clr mid-ACCESS of a loader write
        ldr_write(4'h7, 8'hC3, lat);
        chk("lit_clr_pre_we", ram_we, 1);
        g_cpu = n_cpu_gnt; g_ldr = n_ldr_gnt; r0 = n_rv;
        clr = 1'b1;
        #1;
        chk("lit_clr_we_drop", ram_we, 0);
        chk("lit_clr_busy_drop", busy, 0);
        tick();
        clr = 1'b0;
        repeat (4) tick();
        chk("lit_clr_no_gnt", (n_cpu_gnt - g_cpu) + (n_ldr_gnt - g_ldr), 0);
        chk("lit_clr_no_rvalid", n_rv - r0, 0);
        cpu_read(4'h7, d, lat);
        chk("lit_clr_write_dropped", d, 8'h00);
        $display("clr mid-write: addr 7 reads %0h", d);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard stop in case anything stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
